// File: rtl/cacheline_mem_arbiter_if.sv
// Bundle of icache, dcache and physical-memory signals seen by the arbiter,
// plus debug taps exposing the arbiter FSM state and starvation streak.
interface cacheline_mem_arbiter_if #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int MAX_D_STREAK = 4
);
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

  // Handshake: i_read / d_read / d_write are level requests held until the
  // matching one-cycle *_resp pulse; pmem_read / pmem_write are held stable
  // until the one-cycle pmem_resp pulse, which also qualifies pmem_rdata.
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  logic                grant_i;
  logic                grant_d;
  logic [1:0]          dbg_state;
  logic [STREAK_W-1:0] dbg_streak;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata,
           grant_i, grant_d, dbg_state, dbg_streak
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata,
           grant_i, grant_d, dbg_state, dbg_streak
  );
endinterface

// File: rtl/cacheline_mem_arbiter.sv
// Shares one cacheline memory port between icache and dcache: data wins ties,
// but an instruction read waits behind at most MAX_D_STREAK data grants.
module cacheline_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  cacheline_mem_arbiter_if.slave  bus
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e            state_q;
  logic [SW-1:0]     streak_q;
  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  logic d_req;
  logic d_wins;

  assign d_req  = bus.d_read | bus.d_write;
  // Data wins unless an instruction read is waiting and the streak is used up.
  assign d_wins = d_req & (~bus.i_read | (streak_q < STREAK_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_wins) begin
            state_q  <= SERVE_D;
            streak_q <= bus.i_read ? streak_q + SW'(1) : '0;
            // A write-back beats a read if both are (illegally) raised.
            wr_q     <= bus.d_write;
            rd_q     <= ~bus.d_write;
            addr_q   <= bus.d_address;
            wdata_q  <= bus.d_wdata;
          end else if (bus.i_read) begin
            state_q  <= SERVE_I;
            streak_q <= '0;
            rd_q     <= 1'b1;
            wr_q     <= 1'b0;
            addr_q   <= bus.i_address;
            wdata_q  <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.pmem_resp) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  assign bus.grant_i    = (state_q == SERVE_I);
  assign bus.grant_d    = (state_q == SERVE_D);
  assign bus.dbg_state  = state_q;
  assign bus.dbg_streak = streak_q;

  // Completion is forwarded in the same cycle; data is valid only with resp.
  assign bus.i_resp  = bus.grant_i & bus.pmem_resp;
  assign bus.d_resp  = bus.grant_d & bus.pmem_resp;
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;
endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Self-checking bench for cacheline_mem_arbiter: directed scenarios plus a
// randomized run checked against a request-level arbitration model.
module tb_cacheline_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int MAX_D  = 4;
  localparam int EXP_W  = 4 + ADDR_W + LINE_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MAX_D_STREAK(MAX_D)) bus ();

  cacheline_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MAX_D_STREAK(MAX_D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [EXP_W-1:0] exp_q[$];

  logic [3:0] st;
  logic [1:0] rs;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.i_read     = 1'b0;
    bus.i_address  = '0;
    bus.d_read     = 1'b0;
    bus.d_write    = 1'b0;
    bus.d_address  = '0;
    bus.d_wdata    = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;
  endtask

  task automatic rand_line(output logic [LINE_W-1:0] v);
    for (int k = 0; k < LINE_W / 32; k++) v[32*k +: 32] = $urandom;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    st = {bus.grant_i, bus.grant_d, bus.pmem_read, bus.pmem_write};
    n_cmp++;
    if (st !== 4'b0000 || {bus.i_resp, bus.d_resp} !== 2'b00) begin
      n_err++; $display("FAIL reset_flags: got %b/%b expected 0000/00", st, {bus.i_resp, bus.d_resp});
    end
    n_cmp++;
    if (bus.pmem_address !== '0 || bus.pmem_wdata !== '0 || bus.dbg_streak !== '0) begin
      n_err++; $display("FAIL reset_fields: got addr %h streak %0d expected 0 0", bus.pmem_address, bus.dbg_streak);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    st = {bus.grant_i, bus.grant_d, bus.pmem_read, bus.pmem_write};
    n_cmp++;
    if (st !== 4'b0000) begin
      n_err++; $display("FAIL reset_release: got %b expected 0000", st);
    end
  endtask

  task automatic test_lone_fetch();
    logic [LINE_W-1:0] a5;
    a5 = {32{8'hA5}};
    @(negedge clk);
    bus.i_read = 1'b1; bus.i_address = 32'h0000_1000;
    #1;
    st = {bus.grant_i, bus.grant_d, bus.pmem_read, bus.pmem_write};
    n_cmp++;
    if (st !== 4'b0000) begin
      n_err++; $display("FAIL fetch_no_comb_path: got %b expected 0000", st);
    end
    @(negedge clk); #1;
    st = {bus.grant_i, bus.grant_d, bus.pmem_read, bus.pmem_write};
    n_cmp++;
    if (st !== 4'b1010 || bus.pmem_address !== 32'h0000_1000) begin
      n_err++; $display("FAIL fetch_grant: got %b addr %h expected 1010 addr 00001000", st, bus.pmem_address);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (bus.pmem_read !== 1'b1 || bus.i_resp !== 1'b0) begin
        n_err++; $display("FAIL fetch_wait: got read %b resp %b expected 1 0", bus.pmem_read, bus.i_resp);
      end
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = a5;
    #1;
    n_cmp++;
    if ({bus.i_resp, bus.d_resp} !== 2'b10 || bus.i_rdata !== a5) begin
      n_err++; $display("FAIL fetch_resp: got resp %b rdata %h expected 10 rdata %h", {bus.i_resp, bus.d_resp}, bus.i_rdata, a5);
    end
    @(negedge clk);
    bus.i_read = 1'b0; bus.pmem_resp = 1'b0;
    #1;
    st = {bus.grant_i, bus.grant_d, bus.pmem_read, bus.pmem_write};
    n_cmp++;
    if (st !== 4'b0000) begin
      n_err++; $display("FAIL fetch_idle_after: got %b expected 0000", st);
    end
  endtask

  task automatic test_simultaneous();
    logic [LINE_W-1:0] w5a;
    logic [ADDR_W-1:0] ia;
    w5a = {32{8'h5A}};
    ia  = {$urandom} & 32'hFFFF_FFE0;
    @(negedge clk);
    bus.i_read = 1'b1; bus.i_address = ia;
    bus.d_write = 1'b1; bus.d_address = 32'h0000_2000; bus.d_wdata = w5a;
    @(negedge clk); #1;
    st = {bus.grant_i, bus.grant_d, bus.pmem_read, bus.pmem_write};
    n_cmp++;
    if (st !== 4'b0101 || bus.pmem_address !== 32'h0000_2000 || bus.pmem_wdata !== w5a) begin
      n_err++; $display("FAIL simul_d_first: got %b addr %h expected 0101 addr 00002000", st, bus.pmem_address);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if ({bus.i_resp, bus.d_resp} !== 2'b01) begin
      n_err++; $display("FAIL simul_d_resp: got %b expected 01", {bus.i_resp, bus.d_resp});
    end
    @(negedge clk);
    bus.d_write = 1'b0; bus.pmem_resp = 1'b0;
    #1;
    st = {bus.grant_i, bus.grant_d, bus.pmem_read, bus.pmem_write};
    n_cmp++;
    if (st !== 4'b0000) begin
      n_err++; $display("FAIL simul_turnaround: got %b expected 0000", st);
    end
    @(negedge clk); #1;
    st = {bus.grant_i, bus.grant_d, bus.pmem_read, bus.pmem_write};
    n_cmp++;
    if (st !== 4'b1010 || bus.pmem_address !== ia) begin
      n_err++; $display("FAIL simul_i_second: got %b addr %h expected 1010 addr %h", st, bus.pmem_address, ia);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if ({bus.i_resp, bus.d_resp} !== 2'b10) begin
      n_err++; $display("FAIL simul_i_resp: got %b expected 10", {bus.i_resp, bus.d_resp});
    end
    @(negedge clk);
    bus.i_read = 1'b0; bus.pmem_resp = 1'b0;
  endtask

  task automatic test_starvation();
    logic exp_i;
    @(negedge clk);
    bus.i_read = 1'b1; bus.i_address = 32'h0000_4000;
    bus.d_read = 1'b1; bus.d_address = 32'h0000_8000;
    for (int k = 0; k <= MAX_D; k++) begin
      exp_i = (k == MAX_D);
      @(negedge clk); #1;
      n_cmp++;
      if ({bus.grant_i, bus.grant_d} !== {exp_i, ~exp_i}) begin
        n_err++; $display("FAIL starve_grant%0d: got %b expected %b", k, {bus.grant_i, bus.grant_d}, {exp_i, ~exp_i});
      end
      if (exp_i) begin
        n_cmp++;
        if (bus.dbg_streak !== '0) begin
          n_err++; $display("FAIL starve_streak_clear: got %0d expected 0", bus.dbg_streak);
        end
      end
      @(negedge clk);
      bus.pmem_resp = 1'b1;
      #1;
      n_cmp++;
      if ({bus.i_resp, bus.d_resp} !== {exp_i, ~exp_i}) begin
        n_err++; $display("FAIL starve_resp%0d: got %b expected %b", k, {bus.i_resp, bus.d_resp}, {exp_i, ~exp_i});
      end
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (exp_i) begin
        bus.i_read = 1'b0; bus.d_read = 1'b0;
      end
      #1;
      if (k == MAX_D - 1) begin
        n_cmp++;
        if (bus.dbg_streak !== MAX_D) begin
          n_err++; $display("FAIL starve_streak_sat: got %0d expected %0d", bus.dbg_streak, MAX_D);
        end
      end
    end
  endtask

  task automatic test_illegal_op();
    logic [LINE_W-1:0] wd;
    logic [ADDR_W-1:0] da;
    int lat;
    rand_line(wd);
    da  = $urandom;
    lat = $urandom_range(0, 3);
    @(negedge clk);
    bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_address = da; bus.d_wdata = wd;
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.pmem_read, bus.pmem_write} !== 2'b01 || bus.pmem_wdata !== wd || bus.pmem_address !== da) begin
      n_err++; $display("FAIL illegal_op: got rd/wr %b addr %h expected 01 addr %h", {bus.pmem_read, bus.pmem_write}, bus.pmem_address, da);
    end
    repeat (lat) @(negedge clk);
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if ({bus.i_resp, bus.d_resp} !== 2'b01) begin
      n_err++; $display("FAIL illegal_resp: got %b expected 01", {bus.i_resp, bus.d_resp});
    end
    @(negedge clk);
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.pmem_resp = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.d_write = 1'b1; bus.d_address = 32'h0000_C000; rand_line(bus.d_wdata);
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.grant_d, bus.pmem_write} !== 2'b11) begin
      n_err++; $display("FAIL rstmid_pre: got %b expected 11", {bus.grant_d, bus.pmem_write});
    end
    bus.pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if (bus.d_resp !== 1'b1) begin
      n_err++; $display("FAIL rstmid_resp_pre: got %b expected 1", bus.d_resp);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.grant_d, bus.pmem_write, bus.d_resp} !== 3'b000) begin
      n_err++; $display("FAIL rstmid_async_drop: got %b expected 000", {bus.grant_d, bus.pmem_write, bus.d_resp});
    end
    bus.d_write = 1'b0; bus.pmem_resp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if ({bus.i_resp, bus.d_resp} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_stray_resp: got %b expected 00", {bus.i_resp, bus.d_resp});
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    st = {bus.grant_i, bus.grant_d, bus.pmem_read, bus.pmem_write};
    n_cmp++;
    if (st !== 4'b0000) begin
      n_err++; $display("FAIL rstmid_stay_idle: got %b expected 0000", st);
    end
  endtask

  task automatic test_input_stability();
    @(negedge clk);
    bus.i_read = 1'b1; bus.i_address = 32'h0000_1000;
    @(negedge clk); #1;
    n_cmp++;
    if (bus.grant_i !== 1'b1 || bus.pmem_address !== 32'h0000_1000) begin
      n_err++; $display("FAIL stable_grant: got %b addr %h expected 1 addr 00001000", bus.grant_i, bus.pmem_address);
    end
    bus.i_address = 32'h0000_3000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (bus.pmem_address !== 32'h0000_1000 || bus.pmem_read !== 1'b1) begin
        n_err++; $display("FAIL stable_hold%0d: got addr %h rd %b expected 00001000 1", c, bus.pmem_address, bus.pmem_read);
      end
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if (bus.i_resp !== 1'b1 || bus.pmem_address !== 32'h0000_1000) begin
      n_err++; $display("FAIL stable_resp: got resp %b addr %h expected 1 00001000", bus.i_resp, bus.pmem_address);
    end
    @(negedge clk);
    bus.i_read = 1'b0; bus.pmem_resp = 1'b0;
  endtask

  task automatic test_random();
    logic              i_pend = 1'b0, d_pend = 1'b0;
    logic              d_rd = 1'b0, d_wr = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0, d_addr = '0;
    logic [LINE_W-1:0] d_wd = '0, rd_line;
    int                streak_m = 0;
    logic              win_i, win_d, e_rd, e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wd;
    logic [EXP_W-1:0]  e;
    int                lat, op;
    @(negedge clk); #1;
    for (int t = 0; t < 80; t++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1'b1; i_addr = $urandom;
        bus.i_read = 1'b1; bus.i_address = i_addr;
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        op = $urandom_range(0, 4);
        d_pend = 1'b1; d_rd = (op <= 1) || (op == 4); d_wr = (op >= 2);
        d_addr = $urandom; rand_line(d_wd);
        bus.d_read = d_rd; bus.d_write = d_wr; bus.d_address = d_addr; bus.d_wdata = d_wd;
      end
      // Reference: data first, unless the waiting fetch has been passed over MAX_D times.
      win_d = d_pend && (!i_pend || streak_m < MAX_D);
      win_i = !win_d && i_pend;
      if (win_d) streak_m = i_pend ? streak_m + 1 : 0;
      if (win_i) streak_m = 0;
      if (!win_i && !win_d) begin
        @(negedge clk); #1;
        st = {bus.grant_i, bus.grant_d, bus.pmem_read, bus.pmem_write};
        n_cmp++;
        if (st !== 4'b0000) begin
          n_err++; $display("FAIL rand_idle%0d: got %b expected 0000", t, st);
        end
        continue;
      end
      e_wr = win_d && d_wr;
      e_rd = win_i || (win_d && !d_wr);
      e_addr = win_d ? d_addr : i_addr;
      e_wd = d_wd;
      exp_q.push_back({win_i, win_d, e_rd, e_wr, e_addr, e_wd});
      @(negedge clk); #1;
      e = exp_q.pop_front();
      st = {bus.grant_i, bus.grant_d, bus.pmem_read, bus.pmem_write};
      n_cmp++;
      if (st !== e[EXP_W-1 -: 4] || bus.pmem_address !== e[LINE_W +: ADDR_W]) begin
        n_err++; $display("FAIL rand_grant%0d: got %b addr %h expected %b addr %h", t, st, bus.pmem_address, e[EXP_W-1 -: 4], e[LINE_W +: ADDR_W]);
      end
      if (e_wr) begin
        n_cmp++;
        if (bus.pmem_wdata !== e[LINE_W-1:0]) begin
          n_err++; $display("FAIL rand_wdata%0d: got %h expected %h", t, bus.pmem_wdata, e[LINE_W-1:0]);
        end
      end
      if (win_i) bus.i_address = $urandom;
      else begin bus.d_address = $urandom; rand_line(bus.d_wdata); end
      lat = $urandom_range(0, 4);
      for (int c = 0; c < lat; c++) begin
        @(negedge clk); #1;
        st = {bus.grant_i, bus.grant_d, bus.pmem_read, bus.pmem_write};
        n_cmp++;
        if (st !== e[EXP_W-1 -: 4] || bus.pmem_address !== e_addr) begin
          n_err++; $display("FAIL rand_hold%0d: got %b addr %h expected %b addr %h", t, st, bus.pmem_address, e[EXP_W-1 -: 4], e_addr);
        end
      end
      @(negedge clk);
      rand_line(rd_line);
      bus.pmem_resp = 1'b1; bus.pmem_rdata = rd_line;
      #1;
      rs = {bus.i_resp, bus.d_resp};
      n_cmp++;
      if (rs !== {win_i, win_d} || (win_i ? bus.i_rdata : bus.d_rdata) !== rd_line) begin
        n_err++; $display("FAIL rand_resp%0d: got %b expected %b", t, rs, {win_i, win_d});
      end
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (win_i) begin bus.i_read = 1'b0; i_pend = 1'b0; end
      else begin bus.d_read = 1'b0; bus.d_write = 1'b0; d_pend = 1'b0; end
      #1;
      st = {bus.grant_i, bus.grant_d, bus.pmem_read, bus.pmem_write};
      n_cmp++;
      if (st !== 4'b0000) begin
        n_err++; $display("FAIL rand_turnaround%0d: got %b expected 0000", t, st);
      end
    end
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_starvation();
    test_illegal_op();
    test_reset_mid();
    test_input_stability();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
